// File: rtl/memory_flash_reader_if.sv
// Bundles the control, memory-port and output-stream signals of the flash reader.
// The master modport is the reader itself. The slave modport is whoever drives
// it: the controller, the memory and the consumer.
interface memory_flash_reader_if;
  // control
  logic        i_start;
  logic [18:0] i_start_address;
  logic [18:0] i_length;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  // memory read port
  logic        o_request;
  logic        i_busy;
  logic [18:0] o_address;
  logic        i_ack;
  logic [31:0] i_data;
  // output stream
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  // debug: current FSM state
  logic [1:0]  o_state;

  modport master (
    input  i_start, i_start_address, i_length, i_abort,
    input  i_busy, i_ack, i_data, i_ready,
    output o_busy, o_done, o_request, o_address, o_valid, o_data, o_state
  );

  modport slave (
    output i_start, i_start_address, i_length, i_abort,
    output i_busy, i_ack, i_data, i_ready,
    input  o_busy, o_done, o_request, o_address, o_valid, o_data, o_state
  );
endinterface

// File: rtl/memory_flash_reader.sv
// Streams a block of 32-bit words out of a word-addressed memory into a small FIFO.
//
// Handshakes:
//   Memory request: a request is taken on any cycle where o_request && !i_busy.
//     o_request and o_address only change after a request is taken or the state changes.
//   Read data: it returns as one-cycle i_ack strobes, in request order, at least one cycle after the request.
//   Output stream: a word is popped on any cycle where o_valid && i_ready.
//     o_valid does not depend on i_ready.
// Requests are issued only while (outstanding + fifo_count) < DEPTH. Every word
// in flight therefore already has a FIFO slot reserved, and the FIFO cannot overflow.
module memory_flash_reader #(
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  memory_flash_reader_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [18:0]     addr_q, addr_d;
  logic [18:0]     remaining_q, remaining_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            done_q, done_d;
  logic [31:0]     mem_q [DEPTH];

  logic            in_fetch;
  logic [CW:0]     in_use;
  logic            request;
  logic            accept;
  logic            ack_ok;
  logic            abort_now;
  logic            push;
  logic            valid;
  logic            pop;
  logic            finish;

  assign in_fetch  = (state_q == S_FETCH);
  assign in_use    = {1'b0, outstanding_q} + {1'b0, count_q};
  assign request   = in_fetch && (remaining_q != 19'd0) && (in_use < DEPTH_C);
  assign accept    = request && !bus.i_busy;
  // Strobes with nothing outstanding belong to an abandoned transfer.
  assign ack_ok    = bus.i_ack && (outstanding_q != '0);
  assign abort_now = in_fetch && bus.i_abort;
  assign push      = in_fetch && ack_ok && !abort_now;
  assign valid     = in_fetch && (count_q != '0);
  assign pop       = valid && bus.i_ready && !abort_now;
  assign finish    = in_fetch && (remaining_q == 19'd0) && (outstanding_q == '0) && (count_q == '0);

  // Next-state and datapath update for the transfer FSM and FIFO bookkeeping.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(ack_ok);
    count_d       = count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d       = S_FETCH;
          addr_d        = bus.i_start_address;
          remaining_d   = bus.i_length;
          outstanding_d = '0;
          count_d       = '0;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
        end
      end
      S_FETCH: begin
        if (accept) begin
          addr_d      = addr_q + 19'd1;
          remaining_d = remaining_q - 19'd1;
        end
        // Abort wins over completion. The FIFO is emptied on the way into FLUSH.
        if (abort_now) begin
          state_d  = S_FLUSH;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else if (finish) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        if (outstanding_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      done_q        <= done_d;
    end
  end

  // FIFO storage. Its contents are only visible through o_valid, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_done    = done_q;
  assign bus.o_request = request;
  assign bus.o_address = addr_q;
  assign bus.o_valid   = valid;
  assign bus.o_data    = valid ? mem_q[rd_ptr_q] : 32'd0;
  assign bus.o_state   = state_q;
endmodule

// File: tb/tb_memory_flash_reader.sv
// Bench for memory_flash_reader: a memory responder with random stall and latency,
// a random consumer, and expected queues built from the start address and length.
module tb_memory_flash_reader;
  localparam int DEPTH = 4;

  typedef struct {
    logic [18:0] start;
    int          len;
    int          busy_pct;
    int          ready_pct;
    int          lat_min;
    int          lat_max;
    int          exp_reqs;
    int          exp_done;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_flash_reader_if bus ();

  memory_flash_reader #(.DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.master)
  );

  // scoreboard state
  int          total;
  int          bad;
  int          cyc;
  int          start_cyc;
  int          last_due;
  logic [31:0] exp_q[$];
  logic [18:0] exp_addr_q[$];
  logic [18:0] pend_addr_q[$];
  int          pend_due_q[$];
  int          acc_cnt;
  int          pop_cnt;
  int          done_cnt;
  int          done_cyc;
  int          busy_pct;
  int          ready_pct;
  int          lat_min;
  int          lat_max;
  bit          prev_stalled;
  logic [18:0] prev_addr;

  // Contents of the memory model: an arbitrary, address-unique pattern.
  function automatic logic [31:0] mem_word(input logic [18:0] a);
    return {a[7:0], ~a[18:11], a[18:3]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle. Entered at a negedge: look at outputs, drive inputs, advance to the next negedge.
  task automatic step();
    logic [18:0] a;
    int due;
    if (bus.o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stalled) begin
      check("req_hold", bus.o_request, 1);
      check("addr_hold", bus.o_address, prev_addr);
    end
    bus.i_busy  = ($urandom_range(0, 99) < busy_pct);
    bus.i_ready = ($urandom_range(0, 99) < ready_pct);
    if (pend_addr_q.size() > 0 && pend_due_q[0] <= cyc) begin
      a = pend_addr_q.pop_front();
      void'(pend_due_q.pop_front());
      bus.i_ack  = 1'b1;
      bus.i_data = mem_word(a);
    end else begin
      bus.i_ack  = 1'b0;
      bus.i_data = $urandom;
    end
    if (bus.o_request && !bus.i_busy) begin
      acc_cnt++;
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_request: got address %0h expected no request", bus.o_address);
      end else begin
        check("req_addr", bus.o_address, exp_addr_q.pop_front());
      end
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due < last_due) due = last_due;
      last_due = due;
      pend_addr_q.push_back(bus.o_address);
      pend_due_q.push_back(due);
      check("credit", ((acc_cnt - pop_cnt) <= DEPTH), 1);
    end
    if (bus.o_valid && bus.i_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_pop: got data %0h expected none", bus.o_data);
      end else begin
        check("pop_data", bus.o_data, exp_q.pop_front());
      end
    end
    prev_stalled = bus.o_request && bus.i_busy && !bus.i_abort;
    prev_addr    = bus.o_address;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Build the expected address and data sequences, then pulse i_start for one cycle.
  task automatic begin_xfer(input logic [18:0] start, input int len);
    logic [18:0] a;
    a = start;
    exp_q.delete();
    exp_addr_q.delete();
    acc_cnt  = 0;
    pop_cnt  = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 0; k < len; k++) begin
      exp_addr_q.push_back(a);
      exp_q.push_back(mem_word(a));
      a = a + 19'd1;
    end
    bus.i_start_address = start;
    bus.i_length        = len[18:0];
    bus.i_start         = 1'b1;
    start_cyc           = cyc;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no o_done after %0d cycles, expected one", budget);
    end
    repeat (3) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_done"}, bus.o_done, 0);
    check({tag, "_request"}, bus.o_request, 0);
    check({tag, "_address"}, bus.o_address, 0);
    check({tag, "_valid"}, bus.o_valid, 0);
    check({tag, "_data"}, bus.o_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   n;
    vecs[0] = '{19'h00010, 3, 0, 100, 2, 2, 3, 1};
    vecs[1] = '{19'h7FFFE, 3, 50, 100, 1, 3, 3, 1};
    vecs[2] = '{19'h00100, 1, 0, 100, 1, 1, 1, 1};
    vecs[3] = '{19'h12345, 9, 20, 70, 1, 4, 9, 1};
    vecs[4] = '{19'h7FFFC, 6, 40, 50, 3, 6, 6, 1};

    total = 0; bad = 0; cyc = 0; last_due = 0; prev_stalled = 0; prev_addr = '0;
    acc_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1; start_cyc = 0;
    busy_pct = 0; ready_pct = 100; lat_min = 1; lat_max = 1;
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_start_address = '0; bus.i_length = '0; bus.i_abort = 1'b0;
    bus.i_busy = 1'b0; bus.i_ack = 1'b0; bus.i_data = '0; bus.i_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 5; i++) begin
      busy_pct = vecs[i].busy_pct; ready_pct = vecs[i].ready_pct;
      lat_min = vecs[i].lat_min; lat_max = vecs[i].lat_max;
      begin_xfer(vecs[i].start, vecs[i].len);
      wait_done(500);
      check("vec_reqs", acc_cnt, vecs[i].exp_reqs);
      check("vec_done", done_cnt, vecs[i].exp_done);
      check("vec_left", exp_q.size(), 0);
      check("vec_idle", bus.o_busy, 0);
    end

    // zero-length transfer
    busy_pct = 0; ready_pct = 100; lat_min = 1; lat_max = 2;
    begin_xfer(19'h00050, 0);
    wait_done(10);
    check("len0_reqs", acc_cnt, 0);
    check("len0_done", done_cnt, 1);
    check("len0_latency", ((done_cyc - start_cyc) <= 2), 1);
    check("len0_idle", bus.o_busy, 0);

    // credit limit under back-pressure, plus a start while busy that must be ignored
    busy_pct = 0; ready_pct = 0; lat_min = 1; lat_max = 3;
    begin_xfer(19'h00200, 8);
    repeat (8) step();
    bus.i_start_address = 19'h07000; bus.i_length = 19'd2; bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    repeat (10) step();
    check("bp_reqs", acc_cnt, DEPTH);
    check("bp_request_low", bus.o_request, 0);
    check("bp_valid", bus.o_valid, 1);
    ready_pct = 100;
    wait_done(200);
    check("bp_total_reqs", acc_cnt, 8);
    check("bp_done", done_cnt, 1);
    check("bp_left", exp_q.size(), 0);

    // abort with two reads in flight
    busy_pct = 0; ready_pct = 0; lat_min = 5; lat_max = 5;
    begin_xfer(19'h00400, 16);
    n = 0;
    while (pend_addr_q.size() < 2 && n < 50) begin
      step();
      n++;
    end
    check("abort_inflight", pend_addr_q.size(), 2);
    busy_pct = 100;
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    busy_pct = 0; ready_pct = 100;
    check("abort_request", bus.o_request, 0);
    check("abort_valid", bus.o_valid, 0);
    check("abort_busy", bus.o_busy, 1);
    for (int i = 0; i < 12; i++) begin
      if (pend_addr_q.size() > 0) check("flush_wait", bus.o_busy, 1);
      check("flush_valid", bus.o_valid, 0);
      step();
    end
    check("abort_absorbed", pend_addr_q.size(), 0);
    check("abort_idle", bus.o_busy, 0);
    check("abort_no_done", done_cnt, 0);

    busy_pct = 20; ready_pct = 80; lat_min = 1; lat_max = 3;
    begin_xfer(19'h00500, 5);
    wait_done(300);
    check("post_abort_reqs", acc_cnt, 5);
    check("post_abort_done", done_cnt, 1);
    check("post_abort_left", exp_q.size(), 0);

    // asynchronous reset mid-transfer, late acks afterwards
    busy_pct = 0; ready_pct = 0; lat_min = 4; lat_max = 4;
    begin_xfer(19'h00600, 16);
    n = 0;
    while (pend_addr_q.size() < 2 && n < 50) begin
      step();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    prev_stalled = 0;
    exp_q.delete();
    exp_addr_q.delete();
    done_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_pct = 100;
    for (int i = 0; i < 10; i++) begin
      check("late_ack_valid", bus.o_valid, 0);
      check("late_ack_busy", bus.o_busy, 0);
      step();
    end
    check("late_ack_drained", pend_addr_q.size(), 0);
    check("late_ack_no_done", done_cnt, 0);

    // randomized transfers
    for (int t = 0; t < 8; t++) begin
      logic [18:0] st;
      int          ln;
      st = $urandom_range(0, 19'h7FFFF);
      if (t == 0) st = 19'h7FFF8;
      ln = $urandom_range(1, 20);
      busy_pct = $urandom_range(0, 60); ready_pct = $urandom_range(30, 100);
      lat_min = $urandom_range(1, 3); lat_max = lat_min + $urandom_range(0, 4);
      begin_xfer(st, ln);
      wait_done(1500);
      check("rand_reqs", acc_cnt, ln);
      check("rand_done", done_cnt, 1);
      check("rand_left", exp_q.size(), 0);
      check("rand_idle", bus.o_busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_flash_reader.md
MEMORY_FLASH_READER -- requirements
Module: memory_flash_reader

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO depth in 32-bit words (power of two, 2..16).
REQ-002 i_clk  input  1  single clock; all logic on rising edge.
REQ-003 i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_start  input  1  one-cycle pulse; begin transfer (ignored unless IDLE).
REQ-005 i_start_address  input  19  first word address, sampled on accepted i_start.
REQ-006 i_length  input  19  word count, sampled on accepted i_start.
REQ-007 i_abort  input  1  stop transfer, discard remaining data.
REQ-008 o_busy  output  1  high in any state other than IDLE.
REQ-009 o_done  output  1  one-cycle pulse on normal completion.
REQ-010 o_request  output  1  read request to memory port.
REQ-011 i_busy  input  1  memory stall; request accepted on cycle with o_request && !i_busy.
REQ-012 o_address  output  19  word address of current request.
REQ-013 i_ack  input  1  one-cycle read-data-valid strobe, in request order, any latency >= 1.
REQ-014 i_data  input  32  read data, valid with i_ack.
REQ-015 o_valid  output  1  FIFO head valid.
REQ-016 i_ready  input  1  consumer pop; pop occurs on o_valid && i_ready.
REQ-017 o_data  output  32  FIFO head word.

Function
REQ-018 States: IDLE, FETCH, FLUSH; o_busy = (state != IDLE).
REQ-019 IDLE + i_start: load address, remaining = i_length, outstanding = 0, go FETCH next cycle.
REQ-020 o_request = FETCH && remaining != 0 && (outstanding + fifo_count) < DEPTH (credit rule); FIFO never overflows.
REQ-021 On accepted request: o_address += 1 (19-bit wrap 7FFFF -> 00000), remaining -= 1, outstanding += 1.
REQ-022 o_address and o_request change only after acceptance or state change; held stable while i_busy.
REQ-023 On i_ack in FETCH: push i_data into FIFO, outstanding -= 1; accept + ack same cycle leaves outstanding unchanged.
REQ-024 Push and pop in same cycle: fifo_count unchanged; pop on empty not possible (o_valid low).
REQ-025 i_ack with outstanding == 0: ignored, no push.
REQ-026 FETCH -> IDLE with o_done pulse when remaining == 0, outstanding == 0, fifo_count == 0 (last word popped), pulse in cycle after condition.
REQ-027 i_length == 0: FETCH for one cycle, no request, o_done pulses, IDLE.
REQ-028 i_abort in FETCH: o_request low from next cycle, go FLUSH; i_abort ignored in IDLE/FLUSH; i_abort has priority over completion in same cycle.
REQ-029 FLUSH: FIFO cleared, o_valid low, acks decrement outstanding and are discarded; -> IDLE when outstanding == 0; no o_done.
REQ-030 i_start while o_busy: ignored.
REQ-031 Data leaves FIFO in memory-address order, unmodified (no byte swap).

Reset
REQ-032 Reset asserted (asynchronous): state IDLE, o_busy 0, o_done 0, o_request 0, o_address 0, o_valid 0, o_data 0, FIFO empty, counters 0.
REQ-033 Reset mid-transfer abandons transfer; acks arriving after release are ignored (REQ-025).
REQ-034 Outputs deassert immediately on reset assertion, not on a clock edge.

Verification
REQ-035 Start addr 0x00010, len 3, i_busy 0, ack latency 2, i_ready 1 -> requests at 10,11,12; o_data sequence matches memory model; one o_done; o_busy returns 0.
REQ-036 Len 8, DEPTH 4, i_ready 0 -> exactly 4 requests then o_request held low; raise i_ready -> remaining 4 fetched, 8 words in order, one o_done.
REQ-037 Start addr 0x7FFFE, len 3 with i_busy toggling -> addresses 7FFFE, 7FFFF, 00000; o_address stable while i_busy.
REQ-038 Len 0 -> no o_request, o_done pulse within 2 cycles of i_start, o_busy 0 after.
REQ-039 Len 16, i_abort with 2 acks outstanding -> o_request low next cycle, o_valid low, 2 acks absorbed, IDLE, no o_done; fresh i_start then works normally.
REQ-040 i_reset_n low mid-transfer with acks outstanding -> all outputs at reset values immediately; late acks after release cause no o_valid.
